sm_muldiv: RTL

Iterative multiply/divide unit with HI/LO result registers for the schoolMIPS core. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width and holds results in architectural HI/LO registers. It also supports MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. It sits beside the single-cycle ALU; the control unit stalls the PC while `busy` is high.

---
 rtl/sm_muldiv_pkg.sv | 25 ++
 rtl/sm_cond_neg.sv | 14 +
 rtl/sm_muldiv.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sm_muldiv_pkg.sv
// rtl/sm_muldiv_pkg.sv - op and state encodings for the sm_muldiv unit
package sm_muldiv_pkg;

   // Operation codes driven by the control unit on op
   localparam logic [1:0] MD_MULTU = 2'd0;
   localparam logic [1:0] MD_MULT  = 2'd1;
   localparam logic [1:0] MD_DIVU  = 2'd2;
   localparam logic [1:0] MD_DIV   = 2'd3;

   // Sequencer states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CALC  = 2'd1;
   localparam logic [1:0] ST_FIXUP = 2'd2;

   // True for the two divide ops
   function automatic logic md_is_div(input logic [1:0] op);
      return (op == MD_DIVU) || (op == MD_DIV);
   endfunction

   // True for the two ops that treat operands as two's complement
   function automatic logic md_is_signed(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/sm_cond_neg.sv
// rtl/sm_cond_neg.sv - conditional two's-complement negate
module sm_cond_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_data,
   input  logic         i_neg,
   output logic [W-1:0] o_data
);

   // The most negative value negates to itself, which is what both the
   // magnitude capture and the MIN/-1 quotient rely on
   assign o_data = i_neg ? (~i_data + W'(1)) : i_data;

endmodule

// File: rtl/sm_muldiv.sv
// rtl/sm_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module sm_muldiv
   import sm_muldiv_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             wrHi,
   input  logic             wrLo,
   input  logic [WIDTH-1:0] wrData,
   output logic             busy,
   output logic             done,
   output logic             divZero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   logic [1:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic               r_is_div;
   logic               r_sign_a;
   logic               r_sign_b;
   logic               r_div_zero;
   logic [WIDTH-1:0]   r_a;        // multiplicand, or dividend shifting out MSB first
   logic [WIDTH-1:0]   r_b;        // multiplier shifting out LSB first, or divisor
   logic [2*WIDTH-1:0] r_acc;      // product, or quotient in the low half
   logic [WIDTH-1:0]   r_rem;      // settled remainder, always below the divisor
   logic               r_done;
   logic               r_dz;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_accept;
   logic               w_signed_op;
   logic               w_sign_a;
   logic               w_sign_b;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_prem;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_accept    = (r_state == ST_IDLE) && start;
   assign w_signed_op = SIGNED_EN && md_is_signed(op);
   assign w_sign_a    = w_signed_op && srcA[WIDTH-1];
   assign w_sign_b    = w_signed_op && srcB[WIDTH-1];

   sm_cond_neg #(.W(WIDTH)) u_mag_a (
      .i_data (srcA),
      .i_neg  (w_sign_a),
      .o_data (w_mag_a)
   );

   sm_cond_neg #(.W(WIDTH)) u_mag_b (
      .i_data (srcB),
      .i_neg  (w_sign_b),
      .o_data (w_mag_b)
   );

   // Shift-add step: add the multiplicand into the upper half when the
   // current multiplier bit is set, then shift the whole product right
   assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);

   // Restoring step: bring down the next dividend bit, keep the difference
   // only when the divisor fits; a zero divisor always fits
   assign w_prem = {r_rem, r_a[WIDTH-1]};
   assign w_ge   = (w_prem >= {1'b0, r_b});
   assign w_diff = w_prem[WIDTH-1:0] - r_b;

   sm_cond_neg #(.W(2*WIDTH)) u_fix_prod (
      .i_data (r_acc),
      .i_neg  (r_sign_a ^ r_sign_b),
      .o_data (w_prod_fix)
   );

   sm_cond_neg #(.W(WIDTH)) u_fix_quo (
      .i_data (r_acc[WIDTH-1:0]),
      .i_neg  (r_sign_a ^ r_sign_b),
      .o_data (w_quo_fix)
   );

   sm_cond_neg #(.W(WIDTH)) u_fix_rem (
      .i_data (r_rem),
      .i_neg  (r_sign_a),
      .o_data (w_rem_fix)
   );

   // Sequencer: IDLE -> CALC for WIDTH cycles -> FIXUP for one cycle -> IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_CALC;
                  r_cnt   <= '0;
               end
            end
            ST_CALC: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state <= ST_FIXUP;
               end
            end
            ST_FIXUP: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b1;
               r_dz    <= r_div_zero;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Operand capture on accept and one iteration per CALC cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_div   <= 1'b0;
         r_sign_a   <= 1'b0;
         r_sign_b   <= 1'b0;
         r_div_zero <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_rem      <= '0;
      end else if (w_accept) begin
         r_is_div   <= md_is_div(op);
         r_sign_a   <= w_sign_a;
         r_sign_b   <= w_sign_b;
         r_div_zero <= md_is_div(op) && (srcB == '0);
         r_a        <= w_mag_a;
         r_b        <= w_mag_b;
         r_acc      <= '0;
         r_rem      <= '0;
      end else if (r_state == ST_CALC) begin
         if (r_is_div) begin
            r_a              <= r_a << 1;
            r_rem            <= w_ge ? w_diff : w_prem[WIDTH-1:0];
            r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_ge};
         end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            r_b   <= r_b >> 1;
         end
      end
   end

   // HI/LO: result write on the FIXUP edge, MTHI/MTLO only when idle and not starting
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == ST_FIXUP) begin
         if (r_is_div) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
         end else begin
            {r_hi, r_lo} <= w_prod_fix;
         end
      end else if ((r_state == ST_IDLE) && !start) begin
         if (wrHi) r_hi <= wrData;
         if (wrLo) r_lo <= wrData;
      end
   end

   assign busy    = (r_state != ST_IDLE);
   assign done    = r_done;
   assign divZero = r_dz;
   assign hi      = r_hi;
   assign lo      = r_lo;

endmodule
